// File: rtl/regfile_write_queue_if.sv
// Write-request bundle from the memory and ALU writeback paths.
// Mem is the older instruction when both fire together.
interface regfile_write_queue_if #(
    parameter int RW = 4,
    parameter int DW = 16
);
    logic          mem_valid;
    logic [RW-1:0] mem_reg;
    logic [DW-1:0] mem_data;
    logic          mem_ready;
    logic          alu_valid;
    logic [RW-1:0] alu_reg;
    logic [DW-1:0] alu_data;
    logic          alu_ready;

    modport master (
        output mem_valid, mem_reg, mem_data,
        input  mem_ready,
        output alu_valid, alu_reg, alu_data,
        input  alu_ready
    );

    modport slave (
        input  mem_valid, mem_reg, mem_data,
        output mem_ready,
        input  alu_valid, alu_reg, alu_data,
        output alu_ready
    );
endinterface

// File: rtl/regfile_write_queue.sv
// Register-file write queue: buffers mem/ALU writes, drains one
// per cycle onto the write port, forwards youngest pending data.
module regfile_write_queue #(
    parameter int DEPTH = 4,
    parameter int RW    = 4,
    parameter int DW    = 16,
    localparam int PW   = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    regfile_write_queue_if.slave  wq,
    input  logic                  rf_stall,
    output logic [RW-1:0]         DstReg,
    output logic [DW-1:0]         DstData,
    output logic                  WriteReg,
    input  logic [RW-1:0]         SrcReg1,
    input  logic [RW-1:0]         SrcReg2,
    output logic                  fwd_hit1,
    output logic [DW-1:0]         fwd_data1,
    output logic                  fwd_hit2,
    output logic [DW-1:0]         fwd_data2,
    output logic [PW:0]           count,
    output logic                  full,
    output logic                  empty
);
    localparam logic [PW:0] LP_FULL = (PW+1)'(DEPTH);
    localparam logic [PW:0] LP_TWO  = (PW+1)'(DEPTH - 2);

    logic [RW-1:0]    r_reg  [DEPTH];
    logic [DW-1:0]    r_data [DEPTH];
    logic [DEPTH-1:0] r_vld;
    logic [PW-1:0]    r_head;
    logic [PW-1:0]    r_tail;
    logic [PW:0]      r_count;
    logic [RW-1:0]    r_dst_reg;
    logic [DW-1:0]    r_dst_data;
    logic             r_we;

    logic             w_full;
    logic             w_empty;
    logic             w_mem_rdy;
    logic             w_alu_rdy;
    logic             w_mem_acc;
    logic             w_alu_acc;
    logic             w_deq;
    logic [PW-1:0]    w_alu_slot;
    logic [PW-1:0]    w_idx;
    logic             w_hit1;
    logic             w_hit2;
    logic [DW-1:0]    w_fd1;
    logic [DW-1:0]    w_fd2;

    assign w_full  = (r_count == LP_FULL);
    assign w_empty = (r_count == '0);

    // ALU needs two free slots when mem competes, since mem goes first
    assign w_mem_rdy = !w_full;
    assign w_alu_rdy = wq.mem_valid ? (r_count <= LP_TWO) : !w_full;

    assign w_mem_acc  = wq.mem_valid && w_mem_rdy;
    assign w_alu_acc  = wq.alu_valid && w_alu_rdy;
    assign w_deq      = !w_empty && !rf_stall;
    assign w_alu_slot = r_tail + PW'(w_mem_acc);

    always_ff @(posedge clk) begin
        if (w_mem_acc) begin
            r_reg[r_tail]  <= wq.mem_reg;
            r_data[r_tail] <= wq.mem_data;
        end
        if (w_alu_acc) begin
            r_reg[w_alu_slot]  <= wq.alu_reg;
            r_data[w_alu_slot] <= wq.alu_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_head     <= '0;
            r_tail     <= '0;
            r_count    <= '0;
            r_vld      <= '0;
            r_dst_reg  <= '0;
            r_dst_data <= '0;
            r_we       <= 1'b0;
        end else begin
            r_we <= w_deq;
            if (w_deq) begin
                r_dst_reg     <= r_reg[r_head];
                r_dst_data    <= r_data[r_head];
                r_vld[r_head] <= 1'b0;
                r_head        <= r_head + PW'(1);
            end
            if (w_mem_acc)
                r_vld[r_tail] <= 1'b1;
            if (w_alu_acc)
                r_vld[w_alu_slot] <= 1'b1;
            r_tail  <= r_tail + PW'(w_mem_acc)
                              + PW'(w_alu_acc);
            r_count <= r_count + (PW+1)'(w_mem_acc)
                               + (PW+1)'(w_alu_acc)
                               - (PW+1)'(w_deq);
        end
    end

    // Walk oldest to youngest so the last match found wins
    always_comb begin
        w_idx  = '0;
        w_hit1 = r_we && (r_dst_reg == SrcReg1);
        w_hit2 = r_we && (r_dst_reg == SrcReg2);
        w_fd1  = w_hit1 ? r_dst_data : '0;
        w_fd2  = w_hit2 ? r_dst_data : '0;
        for (int k = 0; k < DEPTH; k++) begin
            w_idx = r_head + PW'(k);
            if (r_vld[w_idx] && (r_reg[w_idx] == SrcReg1)) begin
                w_hit1 = 1'b1;
                w_fd1  = r_data[w_idx];
            end
            if (r_vld[w_idx] && (r_reg[w_idx] == SrcReg2)) begin
                w_hit2 = 1'b1;
                w_fd2  = r_data[w_idx];
            end
        end
    end

    assign wq.mem_ready = w_mem_rdy;
    assign wq.alu_ready = w_alu_rdy;
    assign DstReg       = r_dst_reg;
    assign DstData      = r_dst_data;
    assign WriteReg     = r_we;
    assign fwd_hit1     = w_hit1;
    assign fwd_data1    = w_fd1;
    assign fwd_hit2     = w_hit2;
    assign fwd_data2    = w_fd2;
    assign count        = r_count;
    assign full         = w_full;
    assign empty        = w_empty;
endmodule

// File: doc/regfile_write_queue.md
Name: regfile_write_queue

Overview:
- Writer-side front end for the 16x16 register file. Buffers register write requests from the ALU and memory writeback paths.
- Serialises the buffered requests onto the single register-file write port (DstReg/DstData/WriteReg), one per cycle, in program order.
- Provides youngest-match forwarding for both read ports, so readers see pending writes before the register file captures them.

Parameters:
- DEPTH, 4, number of queue entries; must be a power of 2, at least 2.
- RW, 4, register index width.
- DW, 16, data width.

Ports:
- clk  in  1  single clock; all state updates on its rising edge.
- rst  in  1  reset, asynchronous, active-low.
- mem_valid  in  1  memory-path write request valid.
- mem_reg  in  RW  destination register of memory request.
- mem_data  in  DW  data of memory request.
- mem_ready  out  1  memory request accepted this cycle when high with mem_valid.
- alu_valid  in  1  ALU-path write request valid.
- alu_reg  in  RW  destination register of ALU request.
- alu_data  in  DW  data of ALU request.
- alu_ready  out  1  ALU request accepted this cycle when high with alu_valid.
- rf_stall  in  1  hold the write port; no dequeue while high.
- DstReg  out  RW  register-file write index (registered).
- DstData  out  DW  register-file write data (registered).
- WriteReg  out  1  register-file write enable (registered).
- SrcReg1  in  RW  read port 1 index, for forwarding lookup.
- SrcReg2  in  RW  read port 2 index, for forwarding lookup.
- fwd_hit1  out  1  a pending write to SrcReg1 exists.
- fwd_data1  out  DW  youngest pending data for SrcReg1; 0 when no hit.
- fwd_hit2  out  1  a pending write to SrcReg2 exists.
- fwd_data2  out  DW  youngest pending data for SrcReg2; 0 when no hit.
- count  out  log2(DEPTH)+1  occupied entries.
- full  out  1  count == DEPTH.
- empty  out  1  count == 0.

Behaviour:
- Reset (rst low, asynchronous): head, tail and count go to 0; entry valid bits cleared; DstReg=0, DstData=0, WriteReg=0. Pending entries are discarded, including mid-operation. Entry data need not be cleared.
- Ready is derived from the registered count only; a same-cycle dequeue gives no credit.
  - mem_ready = !full.
  - alu_ready = (count <= DEPTH-2) when mem_valid is high, else !full.
- Enqueue order: when both requests are accepted in one cycle, the mem entry is written at tail and the ALU entry at tail+1. Mem is the older instruction.
- Pointers wrap modulo DEPTH.
- Dequeue: at a rising edge with !empty && !rf_stall, the head entry is loaded into DstReg/DstData, WriteReg becomes 1, and head advances. Otherwise WriteReg becomes 0; DstReg and DstData hold their values.
- count_next = count + accepted(0..2) - dequeued(0..1). Simultaneous enqueue and dequeue are legal at any occupancy, including full (dequeue only) and empty (enqueue only).
- Latency: request accepted at edge N → WriteReg high in cycle N+1..N+2 → register file captures at edge N+2. There is no bypass from input straight to output.
- Forwarding is combinational. It searches the output stage (when WriteReg=1) and all valid queue entries.
  - Priority, youngest first: the entry nearest tail, then older entries toward head, then the output stage.
  - Same-cycle incoming requests are not searched.
  - No special casing of register 0.
- rf_stall high with WriteReg=1: WriteReg drops to 0 at the next edge. The write already presented completes at that edge.

Test Plan:
- Reset: hold rst low two cycles, mid-traffic with 3 entries queued → count=0, empty=1, WriteReg=0, DstReg=0, DstData=0, fwd_hit1/2=0.
- Single write: alu_valid, alu_reg=5, alu_data=16'hBEEF at edge 1 → WriteReg=1, DstReg=5, DstData=16'hBEEF after edge 2, then WriteReg=0.
- Dual enqueue order: same cycle mem(reg 3, 16'h1111) and alu(reg 3, 16'h2222), SrcReg1=3, rf_stall=1.
  - Required: count=2, fwd_data1=16'h2222.
  - Release rf_stall → writes appear in order 1111 then 2222 on consecutive cycles.
- Full/backpressure: rf_stall=1, offer 5 ALU requests → 4 accepted; alu_ready=0 with full=1. With count=3 and both valid → mem_ready=1, alu_ready=0.
- Wrap-around: 10 writes to regs 0..9 with rf_stall toggling every 2 cycles → WriteReg sequence is regs 0..9 in order with matching data; no loss or duplication.
- Forwarding from output stage: a single entry for reg 7 (16'h00AA) has just been dequeued and nothing else is pending; SrcReg2=7 → fwd_hit2=1, fwd_data2=16'h00AA while WriteReg=1; fwd_hit2=0 the cycle after.
